// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected layer sequencer:
// FSM states, width defaults, saturation and memory-layout offsets.
package fc_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned ACC_W_DEF  = 40;
   localparam int unsigned SAT_W      = 128;

   typedef enum logic [2:0] {
      IDLE,
      LD_IN,
      LD_W,
      LD_B,
      WR,
      DONE
   } fc_state_e;

   // Clamp a wide signed value to the signed range of a dw-bit word.
   function automatic logic signed [SAT_W-1:0] sat_to_data(input logic signed [SAT_W-1:0] s,
                                                           input int unsigned dw);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (SAT_W'(1) <<< (dw - 32'd1)) - SAT_W'(1);
      lo = -hi - SAT_W'(1);
      if (s > hi) return hi;
      else if (s < lo) return lo;
      else return s;
   endfunction

   // Word offsets from the layer base: inputs, weights, biases, outputs.
   function automatic int unsigned w_off(input int unsigned n_in, input int unsigned j,
                                         input int unsigned i);
      return n_in + j * n_in + i;
   endfunction

   function automatic int unsigned b_off(input int unsigned n_in, input int unsigned n_out,
                                         input int unsigned j);
      return n_in + n_in * n_out + j;
   endfunction

   function automatic int unsigned o_off(input int unsigned n_in, input int unsigned n_out,
                                         input int unsigned j);
      return n_in + n_in * n_out + n_out + j;
   endfunction

endpackage

// File: rtl/fc_layer_ctrl_mac.sv
// Signed multiply-accumulate plus combinational shift/bias/saturate for one output node.
// Build option FC_RELU_EN clamps negative results to zero after saturation.
module fc_mac
   import fc_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned ACC_W     = ACC_W_DEF,
   parameter int unsigned FRAC_BITS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [DATA_W-1:0] bias_i,
   output logic [DATA_W-1:0] result_c_o
);

   localparam int unsigned PROD_W = 2 * DATA_W;

   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  acc_d;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  sum;
   logic signed [SAT_W-1:0]  sat;
   logic [DATA_W-1:0]        res;

   always_comb begin
      prod  = PROD_W'($signed(a_i)) * PROD_W'($signed(b_i));
      acc_d = acc_q;
      if (clr_i)     acc_d = '0;
      else if (en_i) acc_d = acc_q + ACC_W'(prod);
   end

   always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end

   // Result uses the finished accumulator and the bias word currently on the bus.
   always_comb begin
      sum = (acc_q >>> FRAC_BITS) + ACC_W'($signed(bias_i));
      sat = sat_to_data(SAT_W'(sum), DATA_W);
      res = DATA_W'(sat);
`ifdef FC_RELU_EN
      if (res[DATA_W-1]) res = '0;
`endif
      result_c_o = res;
   end

endmodule

// File: rtl/fc_layer_ctrl.sv
// Fully-connected layer sequencer over a shared req/gnt/rvalid memory.
// Output ReLU selectable with FC_RELU_EN (see fc_mac); FSM and timing are unaffected.
module fc_layer_ctrl
   import fc_pkg::*;
#(
   parameter int unsigned N_IN      = 5,
   parameter int unsigned N_OUT     = 3,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned ACC_W     = ACC_W_DEF,
   parameter int unsigned FRAC_BITS = 8,
   parameter int unsigned ADDR_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int unsigned JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
   localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);

   fc_state_e         state_q;
   logic [ADDR_W-1:0] base_q;
   logic [IW-1:0]     i_q;
   logic [JW-1:0]     j_q;
   logic              wait_q;
   logic              busy_q;
   logic              done_q;
   logic              req_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] in_buf_q [N_IN];

   logic              rd_ok;
   logic              wr_ok;
   logic              mac_en;
   logic              mac_clr;
   logic [DATA_W-1:0] mac_res_c;

   assign rd_ok   = wait_q & mem_rvalid;
   assign wr_ok   = req_q & mem_gnt & we_q;
   assign mac_en  = (state_q == LD_W) & rd_ok;
   assign mac_clr = ((state_q == LD_IN) & rd_ok & (i_q == I_LAST)) | ((state_q == WR) & wr_ok);

   fc_mac #(
      .DATA_W    (DATA_W),
      .ACC_W     (ACC_W),
      .FRAC_BITS (FRAC_BITS)
   ) u_mac (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (mac_clr),
      .en_i       (mac_en),
      .a_i        (mem_rdata),
      .b_i        (in_buf_q[i_q]),
      .bias_i     (mem_rdata),
      .result_c_o (mac_res_c)
   );

   // Layout offsets wrap modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] lay_addr(input int unsigned off);
      return base_q + ADDR_W'(off);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         i_q     <= '0;
         j_q     <= '0;
         wait_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         for (int k = 0; k < int'(N_IN); k++) in_buf_q[k] <= '0;
      end else begin
         done_q <= 1'b0;
         // Accepted transfer: drop the request; reads then wait for rvalid.
         if (req_q && mem_gnt) begin
            req_q  <= 1'b0;
            wait_q <= !we_q;
         end
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= LD_IN;
                  base_q  <= base_addr;
                  busy_q  <= 1'b1;
                  i_q     <= '0;
                  j_q     <= '0;
                  req_q   <= 1'b1;
                  we_q    <= 1'b0;
                  addr_q  <= base_addr;
               end
            end
            LD_IN: begin
               if (rd_ok) begin
                  in_buf_q[i_q] <= mem_rdata;
                  wait_q        <= 1'b0;
                  req_q         <= 1'b1;
                  if (i_q == I_LAST) begin
                     i_q     <= '0;
                     state_q <= LD_W;
                     addr_q  <= lay_addr(w_off(N_IN, 32'd0, 32'd0));
                  end else begin
                     i_q    <= i_q + IW'(1);
                     addr_q <= lay_addr(32'(i_q) + 32'd1);
                  end
               end
            end
            LD_W: begin
               if (rd_ok) begin
                  wait_q <= 1'b0;
                  req_q  <= 1'b1;
                  if (i_q == I_LAST) begin
                     i_q     <= '0;
                     state_q <= LD_B;
                     addr_q  <= lay_addr(b_off(N_IN, N_OUT, 32'(j_q)));
                  end else begin
                     i_q    <= i_q + IW'(1);
                     addr_q <= lay_addr(w_off(N_IN, 32'(j_q), 32'(i_q) + 32'd1));
                  end
               end
            end
            LD_B: begin
               if (rd_ok) begin
                  wait_q  <= 1'b0;
                  req_q   <= 1'b1;
                  we_q    <= 1'b1;
                  wdata_q <= mac_res_c;
                  state_q <= WR;
                  addr_q  <= lay_addr(o_off(N_IN, N_OUT, 32'(j_q)));
               end
            end
            WR: begin
               if (wr_ok) begin
                  we_q <= 1'b0;
                  if (j_q == J_LAST) begin
                     state_q <= DONE;
                  end else begin
                     j_q     <= j_q + JW'(1);
                     state_q <= LD_W;
                     req_q   <= 1'b1;
                     addr_q  <= lay_addr(w_off(N_IN, 32'(j_q) + 32'd1, 32'd0));
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Bench for fc_layer_ctrl: vector table of layers run back-to-back against a
// stalling memory model with a write scoreboard, plus busy-start and mid-run reset sequences.
module tb_fc_layer_ctrl;

   localparam int NI = 5;
   localparam int NO = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] base_addr;
   logic        busy, done, mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [15:0] mem_rdata;

   always #5 clk = ~clk;

   fc_layer_ctrl #(
      .N_IN(NI), .N_OUT(NO), .DATA_W(16), .ACC_W(40), .FRAC_BITS(0), .ADDR_W(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic [15:0] base, in0, in_step, w0, wj, wi, b0, b_step;
      bit          stall;
      int          lat;
      logic [15:0] e0, e1, e2;
   } vec_t;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
   } exp_t;

   vec_t        vecs [7];
   exp_t        sb_q [$];
   logic [15:0] mem [0:65535];

   int n_tests = 0;
   int n_fail  = 0;

   bit          stall_en = 1'b0;
   int          rv_fix = 0;
   bit          rv_pend = 1'b0;
   int          rv_cnt = 0;
   logic [15:0] rv_data = '0;
   bit          req_seen = 1'b0;
   int          gdly = 0;
   logic [15:0] cap_addr = '0, cap_wd = '0;
   logic        cap_we = 1'b0;
   int          prot_err = 0;
   int          hi_acc = 0;
   logic [15:0] last_rd_addr = 16'hFFFF;
   int          done_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] post(input logic [15:0] v);
`ifdef FC_RELU_EN
      return v[15] ? 16'h0000 : v;
`else
      return v;
`endif
   endfunction

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   // Memory/arbiter model: decides gnt and rvalid for the next rising edge.
   initial begin : mem_model
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'($urandom);
         if (mem_req && rv_pend) prot_err++;
         if (rv_pend) begin
            if (rv_cnt == 0) begin
               mem_rvalid = 1'b1; mem_rdata = rv_data; rv_pend = 1'b0;
            end else rv_cnt--;
         end
         if (!mem_req) req_seen = 1'b0;
         else begin
            if (!req_seen) begin
               req_seen = 1'b1; cap_addr = mem_addr; cap_we = mem_we; cap_wd = mem_wdata;
               gdly = stall_en ? int'($urandom_range(0, 5)) : 0;
            end else if (mem_addr !== cap_addr || mem_we !== cap_we ||
                         (cap_we && mem_wdata !== cap_wd)) prot_err++;
            if (gdly == 0) begin
               mem_gnt = 1'b1; req_seen = 1'b0;
               if (mem_addr >= 16'h0100 && mem_addr < 16'h0120) hi_acc++;
               if (mem_we) begin
                  mem[mem_addr] = mem_wdata;
                  if (sb_q.size() == 0) begin
                     n_tests++; n_fail++;
                     $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
                  end else begin
                     exp_t e;
                     e = sb_q.pop_front();
                     chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                     chk("wr_data", 32'(mem_wdata), 32'(e.data));
                  end
               end else begin
                  rv_data = mem[mem_addr]; rv_pend = 1'b1; last_rd_addr = mem_addr;
                  rv_cnt = (rv_fix != 0) ? rv_fix - 1 : (stall_en ? int'($urandom_range(1, 4)) - 1 : 0);
               end
            end else gdly--;
         end
      end
   end

   task automatic load(input vec_t v);
      for (int i = 0; i < NI; i++) mem[v.base + 16'(i)] = v.in0 + v.in_step * 16'(i);
      for (int j = 0; j < NO; j++) begin
         for (int i = 0; i < NI; i++)
            mem[v.base + 16'(NI + j * NI + i)] = v.w0 + v.wj * 16'(j) + v.wi * 16'(i);
         mem[v.base + 16'(NI + NI * NO + j)]      = v.b0 + v.b_step * 16'(j);
         mem[v.base + 16'(NI + NI * NO + NO + j)] = 16'hDEAD;
      end
   endtask

   task automatic push_exp(input vec_t v);
      sb_q.push_back('{addr: v.base + 16'd23, data: post(v.e0)});
      sb_q.push_back('{addr: v.base + 16'd24, data: post(v.e1)});
      sb_q.push_back('{addr: v.base + 16'd25, data: post(v.e2)});
   endtask

   // Pulse start, then count cycles until done (start cycle = 0).
   task automatic run(input logic [15:0] base, input bit inject, output int lat);
      int n;
      start = 1'b1; base_addr = base;
      @(negedge clk);
      start = 1'b0; base_addr = 16'hBEEF;
      n = 1;
      chk("busy_after_start", 32'(busy), 32'd1);
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
         if (inject && n == 10) begin start = 1'b1; base_addr = 16'h0100; end
         else if (inject && n == 11) begin start = 1'b0; base_addr = 16'hBEEF; end
      end
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL run_timeout: no done after %0d cycles, expected done", n);
      end
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      lat = n;
   endtask

   initial begin : main
      int lat, d0, n;
      vecs[0] = '{base:16'h0000, in0:16'd1, in_step:16'd1, w0:16'd1, wj:16'd0, wi:16'd0,
                  b0:16'd10, b_step:16'd10, stall:1'b0, lat:51, e0:16'd25, e1:16'd35, e2:16'd45};
      vecs[1] = '{base:16'h0200, in0:16'h7FFF, in_step:16'd0, w0:16'h7FFF, wj:16'd0, wi:16'd0,
                  b0:16'd0, b_step:16'd0, stall:1'b0, lat:51, e0:16'h7FFF, e1:16'h7FFF, e2:16'h7FFF};
      vecs[2] = '{base:16'h0300, in0:16'h7FFF, in_step:16'd0, w0:16'h8000, wj:16'd0, wi:16'd0,
                  b0:16'd0, b_step:16'd0, stall:1'b0, lat:51, e0:16'h8000, e1:16'h8000, e2:16'h8000};
      vecs[3] = '{base:16'h0400, in0:16'hFFFE, in_step:16'd2, w0:16'hFFFD, wj:16'd0, wi:16'd0,
                  b0:16'hFFFB, b_step:16'd7, stall:1'b0, lat:51, e0:16'hFFDD, e1:16'hFFE4, e2:16'hFFEB};
      vecs[4] = '{base:16'h0800, in0:16'd1, in_step:16'd1, w0:16'd1, wj:16'd1, wi:16'd1,
                  b0:16'd100, b_step:16'hFFFF, stall:1'b0, lat:51, e0:16'd155, e1:16'd169, e2:16'd183};
      vecs[5] = '{base:16'h0A00, in0:16'd1, in_step:16'd1, w0:16'd1, wj:16'd0, wi:16'd0,
                  b0:16'd10, b_step:16'd10, stall:1'b1, lat:0, e0:16'd25, e1:16'd35, e2:16'd45};
      vecs[6] = '{base:16'hFFF0, in0:16'd1, in_step:16'd1, w0:16'd1, wj:16'd0, wi:16'd0,
                  b0:16'd10, b_step:16'd10, stall:1'b0, lat:51, e0:16'd25, e1:16'd35, e2:16'd45};

      rst = 1'b1; start = 1'b0; base_addr = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table runs back-to-back: each start lands in the IDLE cycle right after done.
      for (int v = 0; v < 7; v++) begin
         stall_en = vecs[v].stall;
         load(vecs[v]);
         push_exp(vecs[v]);
         run(vecs[v].base, 1'b0, lat);
         if (vecs[v].lat != 0) chk("latency", 32'(lat), 32'(vecs[v].lat));
      end
      stall_en = 1'b0;
      chk("wrap_out0", 32'(mem[16'h0007]), 32'd25);
      chk("wrap_out2", 32'(mem[16'h0009]), 32'd45);

      // Start pulse while busy must be ignored.
      repeat (2) @(negedge clk);
      hi_acc = 0; d0 = done_cnt;
      load(vecs[0]); push_exp(vecs[0]);
      run(16'h0000, 1'b1, lat);
      chk("busy_start_latency", 32'(lat), 32'd51);
      repeat (4) @(negedge clk);
      chk("done_once", 32'(done_cnt - d0), 32'd1);
      chk("no_hi_access", 32'(hi_acc), 32'd0);
      chk("idle_after_ignored_start", 32'(busy), 32'd0);

      // Reset during LD_W of output 1 while its first weight read is outstanding.
      rv_fix = 3; last_rd_addr = 16'hFFFF;
      load(vecs[0]); push_exp(vecs[0]);
      start = 1'b1; base_addr = 16'h0000;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(rv_pend && last_rd_addr == 16'd10) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("reached_ldw_j1", 32'(last_rd_addr), 32'd10);
      @(negedge clk);
      rst = 1'b1; d0 = done_cnt;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_req", 32'(mem_req), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      repeat (6) @(negedge clk);
      chk("late_rvalid_req", 32'(mem_req), 32'd0);
      chk("late_rvalid_busy", 32'(busy), 32'd0);
      chk("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
      sb_q.delete();
      rv_fix = 0;
      push_exp(vecs[0]);
      run(16'h0000, 1'b0, lat);
      chk("fresh_latency", 32'(lat), 32'd51);
      chk("fresh_out1", 32'(mem[16'd24]), 32'd35);

      chk("protocol_errors", 32'(prot_err), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
